rtc_bcd_clock: RTL

Parametrised BCD real-time clock (HH:MM:SS, 24 h) with a 4-bit CPU register port and up to four HH:MM alarm channels. Drives the seven-segment display digits, raises per-channel alarm interrupts, and sits on the peripheral bus beside the display driver, successor to the fixed 50 MHz HH:MM timer.

---
 rtl/rtc_bcd_clock_pkg.sv | 77 +++++++
 rtl/rtc_alarm_cmp.sv | 66 ++++++
 rtl/rtc_bcd_clock.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rtc_bcd_clock_pkg.sv
// Shared definitions for the BCD real-time clock: register map, digit
// limits, time/alarm payload structs and the one-second BCD advance.
package rtc_bcd_clock_pkg;

  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned DATA_W      = 4;
  localparam int unsigned ALARM_OFS_W = 3;   // log2 of the alarm channel stride

  // Time and control registers
  localparam logic [ADDR_W-1:0] ADDR_SEC0   = 11'h000;
  localparam logic [ADDR_W-1:0] ADDR_SEC1   = 11'h001;
  localparam logic [ADDR_W-1:0] ADDR_MIN0   = 11'h002;
  localparam logic [ADDR_W-1:0] ADDR_MIN1   = 11'h003;
  localparam logic [ADDR_W-1:0] ADDR_HOUR0  = 11'h004;
  localparam logic [ADDR_W-1:0] ADDR_HOUR1  = 11'h005;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 11'h006;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 11'h007;

  // Alarm channel k lives at ALARM_BASE + k*ALARM_STRIDE
  localparam logic [ADDR_W-1:0] ALARM_BASE   = 11'h010;
  localparam logic [ADDR_W-1:0] ALARM_STRIDE = 11'h008;
  localparam logic [ALARM_OFS_W-1:0] ALM_MIN0  = 3'd0;
  localparam logic [ALARM_OFS_W-1:0] ALM_MIN1  = 3'd1;
  localparam logic [ALARM_OFS_W-1:0] ALM_HOUR0 = 3'd2;
  localparam logic [ALARM_OFS_W-1:0] ALM_HOUR1 = 3'd3;
  localparam logic [ALARM_OFS_W-1:0] ALM_EN    = 3'd4;

  // Digit limits: a digit at or above its limit wraps to zero with carry
  localparam logic [3:0] LIM_UNITS   = 4'd9;
  localparam logic [2:0] LIM_TENS    = 3'd5;
  localparam logic [1:0] HOUR1_LAST  = 2'd2;
  localparam logic [3:0] HOUR0_AT_20 = 4'd3;

  typedef struct packed {
    logic [1:0] hour1;
    logic [3:0] hour0;
    logic [2:0] min1;
    logic [3:0] min0;
    logic [2:0] sec1;
    logic [3:0] sec0;
  } bcd_time_t;

  typedef struct packed {
    logic [1:0] hour1;
    logic [3:0] hour0;
    logic [2:0] min1;
    logic [3:0] min0;
  } hhmm_t;

  // One-second advance; carries ripple only through this function
  function automatic bcd_time_t bcd_advance(input bcd_time_t t);
    bcd_time_t n;
    logic c_s1, c_m0, c_m1, c_h;
    n    = t;
    c_s1 = (t.sec0 >= LIM_UNITS);
    n.sec0 = c_s1 ? 4'd0 : t.sec0 + 4'd1;
    c_m0 = c_s1 && (t.sec1 >= LIM_TENS);
    if (c_s1) n.sec1 = (t.sec1 >= LIM_TENS) ? 3'd0 : t.sec1 + 3'd1;
    c_m1 = c_m0 && (t.min0 >= LIM_UNITS);
    if (c_m0) n.min0 = (t.min0 >= LIM_UNITS) ? 4'd0 : t.min0 + 4'd1;
    c_h  = c_m1 && (t.min1 >= LIM_TENS);
    if (c_m1) n.min1 = (t.min1 >= LIM_TENS) ? 3'd0 : t.min1 + 3'd1;
    if (c_h) begin
      if (t.hour1 == HOUR1_LAST && t.hour0 >= HOUR0_AT_20) begin
        n.hour1 = 2'd0;
        n.hour0 = 4'd0;
      end else if (t.hour0 >= LIM_UNITS) begin
        n.hour0 = 4'd0;
        n.hour1 = t.hour1 + 2'd1;
      end else begin
        n.hour0 = t.hour0 + 4'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rtc_alarm_cmp.sv
// One HH:MM alarm channel: holds the alarm digits and enable, decodes its
// own register window and flags when the current time is HH:MM:00.
// Ports: clk, rst (sync, active-high); wr (qualified write strobe), address,
// data_in; now (current time); en (enable register); match_c (time equals
// alarm at :00 with enable set); rdata_c (register read value, 0 if not hit).
module rtc_alarm_cmp
  import rtc_bcd_clock_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  bcd_time_t         now,
  output logic              en,
  output logic              match_c,
  output logic [DATA_W-1:0] rdata_c
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ALARM_BASE + IDX * ALARM_STRIDE);

  hhmm_t                  alm;
  logic                   hit;
  logic [ALARM_OFS_W-1:0] ofs;

  assign hit = (address[ADDR_W-1:ALARM_OFS_W] == BASE[ADDR_W-1:ALARM_OFS_W]);
  assign ofs = address[ALARM_OFS_W-1:0];

  // Alarm digit and enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alm <= '0;
      en  <= 1'b0;
    end else if (wr && hit) begin
      case (ofs)
        ALM_MIN0:  alm.min0  <= data_in;
        ALM_MIN1:  alm.min1  <= data_in[2:0];
        ALM_HOUR0: alm.hour0 <= data_in;
        ALM_HOUR1: alm.hour1 <= data_in[1:0];
        ALM_EN:    en        <= data_in[0];
        default:   ;
      endcase
    end
  end

  assign match_c = en && (now.sec1 == 3'd0) && (now.sec0 == 4'd0) &&
                   (now.min0 == alm.min0) && (now.min1 == alm.min1) &&
                   (now.hour0 == alm.hour0) && (now.hour1 == alm.hour1);

  always_comb begin
    rdata_c = '0;
    if (hit) begin
      case (ofs)
        ALM_MIN0:  rdata_c = alm.min0;
        ALM_MIN1:  rdata_c = {1'b0, alm.min1};
        ALM_HOUR0: rdata_c = alm.hour0;
        ALM_HOUR1: rdata_c = {2'b00, alm.hour1};
        ALM_EN:    rdata_c = {3'b000, en};
        default:   rdata_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/rtc_bcd_clock.sv
// BCD 24-hour real-time clock with a 4-bit register port and optional
// HH:MM alarm channels (enabled by defining RTC_ALARM_EN).
// Ports: clk, rst (sync, active-high); sel, write_en, address, data_in,
// data_out (registered read); sec1/sec0, min1/min0, hour1/hour0 (display
// digits); tick_1hz (one-cycle pulse after each second advance);
// alarm_irq (per-channel pending & enable, 0 without RTC_ALARM_EN).
module rtc_bcd_clock
  import rtc_bcd_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned NUM_ALARMS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic [2:0]            sec1,
  output logic [3:0]            sec0,
  output logic [2:0]            min1,
  output logic [3:0]            min0,
  output logic [1:0]            hour1,
  output logic [3:0]            hour0,
  output logic                  tick_1hz,
  output logic [NUM_ALARMS-1:0] alarm_irq
);

  localparam int unsigned     PW    = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   P_MAX = PW'(CLK_HZ - 1);

  bcd_time_t         now;
  logic [PW-1:0]     p;
  logic              run;
  logic              wr;
  logic              time_wr;
  logic              advance;
  logic [DATA_W-1:0] rdata_c;

  assign wr      = sel && write_en;
  assign time_wr = wr && (address <= ADDR_HOUR1);
  // A CPU time write restarts the second and swallows this cycle's advance
  assign advance = run && (p == P_MAX) && !time_wr;

  assign sec0  = now.sec0;
  assign sec1  = now.sec1;
  assign min0  = now.min0;
  assign min1  = now.min1;
  assign hour0 = now.hour0;
  assign hour1 = now.hour1;

  // Prescaler, time digits, control, tick and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      now      <= '0;
      p        <= '0;
      run      <= 1'b1;
      tick_1hz <= 1'b0;
      data_out <= '0;
    end else begin
      if (time_wr) begin
        p <= '0;
        case (address[2:0])
          3'd0:    now.sec0  <= data_in;
          3'd1:    now.sec1  <= data_in[2:0];
          3'd2:    now.min0  <= data_in;
          3'd3:    now.min1  <= data_in[2:0];
          3'd4:    now.hour0 <= data_in;
          3'd5:    now.hour1 <= data_in[1:0];
          default: ;
        endcase
      end else if (advance) begin
        p   <= '0;
        now <= bcd_advance(now);
      end else if (run) begin
        p <= p + PW'(1);
      end
      if (wr && address == ADDR_CTRL) run <= data_in[0];
      tick_1hz <= advance;
      if (sel) data_out <= rdata_c;
    end
  end

`ifdef RTC_ALARM_EN
  logic [NUM_ALARMS-1:0] match_vec;
  logic [NUM_ALARMS-1:0] en_vec;
  logic [NUM_ALARMS-1:0] pending;
  logic [NUM_ALARMS-1:0] w1c;
  logic [NUM_ALARMS-1:0] set;
  logic [DATA_W-1:0]     alm_rd [NUM_ALARMS];
  logic [DATA_W-1:0]     alm_rd_or;

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_alarm
    rtc_alarm_cmp #(.IDX(k)) u_cmp (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .address (address),
      .data_in (data_in),
      .now     (now),
      .en      (en_vec[k]),
      .match_c (match_vec[k]),
      .rdata_c (alm_rd[k])
    );
  end

  always_comb begin
    alm_rd_or = '0;
    for (int i = 0; i < NUM_ALARMS; i++) alm_rd_or = alm_rd_or | alm_rd[i];
  end

  // tick_1hz marks the cycle in which the digits show the freshly advanced time
  assign set = tick_1hz ? match_vec : '0;
  assign w1c = (wr && address == ADDR_STATUS) ? data_in[NUM_ALARMS-1:0] : '0;

  // Pending flags; a new match beats a same-cycle write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~w1c) | set;
  end

  assign alarm_irq = pending & en_vec;
`else
  assign alarm_irq = '0;
`endif

  // Register read mux
  always_comb begin
    rdata_c = '0;
    case (address)
      ADDR_SEC0:   rdata_c = now.sec0;
      ADDR_SEC1:   rdata_c = {1'b0, now.sec1};
      ADDR_MIN0:   rdata_c = now.min0;
      ADDR_MIN1:   rdata_c = {1'b0, now.min1};
      ADDR_HOUR0:  rdata_c = now.hour0;
      ADDR_HOUR1:  rdata_c = {2'b00, now.hour1};
      ADDR_CTRL:   rdata_c = {3'b000, run};
`ifdef RTC_ALARM_EN
      ADDR_STATUS: rdata_c = DATA_W'(pending);
`endif
      default:     rdata_c = '0;
    endcase
`ifdef RTC_ALARM_EN
    rdata_c = rdata_c | alm_rd_or;
`endif
  end

endmodule
